// File: rtl/riscv_dm_pkg.sv
// Shared DMI widths, request/response structs and arbiter state encoding
// used by the Debug Module DMI arbiter and its round-robin grant logic.
package riscv_dm_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;

  typedef struct packed {
    logic [DMI_ADDR_WIDTH-1:0] addr;
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/riscv_dmi_rr_arb.sv
// Combinational round-robin picker: first requester after last_grant,
// wrapping from NUM_MASTERS-1 back to 0.
module riscv_dmi_rr_arb #(
  parameter int NUM_MASTERS = 2,
  localparam int MST_BITS = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MST_BITS-1:0]    last_grant,
  output logic [MST_BITS-1:0]    grant,
  output logic                   any_req
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_MASTERS;
      if (req[idx]) begin
        grant   = MST_BITS'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_dmi_arbiter.sv
// Shares one Debug Module DMI port among NUM_MASTERS requesters with
// round-robin grant and exactly one transaction outstanding.
module riscv_dmi_arbiter
  import riscv_dm_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int MST_BITS = $clog2(NUM_MASTERS)
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic [NUM_MASTERS-1:0]                       m_req_valid_i,
  output logic [NUM_MASTERS-1:0]                       m_req_ready_o,
  input  logic [NUM_MASTERS-1:0][DMI_ADDR_WIDTH-1:0]   m_req_addr_i,
  input  logic [NUM_MASTERS-1:0][DMI_DATA_WIDTH-1:0]   m_req_data_i,
  input  logic [NUM_MASTERS-1:0][DMI_OP_WIDTH-1:0]     m_req_op_i,
  output logic [NUM_MASTERS-1:0]                       m_resp_valid_o,
  input  logic [NUM_MASTERS-1:0]                       m_resp_ready_i,
  output logic [NUM_MASTERS-1:0][DMI_DATA_WIDTH-1:0]   m_resp_data_o,
  output logic [NUM_MASTERS-1:0][DMI_OP_WIDTH-1:0]     m_resp_op_o,
  output logic                                         dm_req_valid_o,
  input  logic                                         dm_req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0]                    dm_req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0]                    dm_req_data_o,
  output logic [DMI_OP_WIDTH-1:0]                      dm_req_op_o,
  input  logic                                         dm_resp_valid_i,
  output logic                                         dm_resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0]                    dm_resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]                      dm_resp_op_i,
  output logic                                         busy_o,
  output logic [MST_BITS-1:0]                          owner_o,
  output arb_state_e                                   state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; a source holds valid and its fields until that edge, and
  // ready never depends on anything but the current state and the peer.

  arb_state_e          state, state_next;
  logic [MST_BITS-1:0] last_grant;
  logic [MST_BITS-1:0] owner;
  logic [MST_BITS-1:0] grant;
  logic                any_req;
  logic                grant_fire;
  logic                resp_fire;
  dmi_req_t            req_q;

  riscv_dmi_rr_arb #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_arb (
    .req        (m_req_valid_i),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  always_comb begin
    state_next      = state;
    m_req_ready_o   = '0;
    m_resp_valid_o  = '0;
    dm_resp_ready_o = 1'b0;
    dm_req_valid_o  = 1'b0;
    grant_fire      = 1'b0;
    resp_fire       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          m_req_ready_o[grant] = 1'b1;
          grant_fire           = 1'b1;
          state_next           = ST_REQ;
        end
      end
      ST_REQ: begin
        dm_req_valid_o = 1'b1;
        if (dm_req_ready_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        m_resp_valid_o[owner] = dm_resp_valid_i;
        dm_resp_ready_o       = m_resp_ready_i[owner];
        resp_fire             = dm_resp_valid_i & m_resp_ready_i[owner];
        if (resp_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response payload is broadcast; only the owner's valid qualifies it.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_resp_data_o[i] = dm_resp_data_i;
      m_resp_op_o[i]   = dm_resp_op_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      last_grant <= MST_BITS'(NUM_MASTERS - 1);
      owner      <= '0;
      req_q      <= '0;
    end else begin
      state <= state_next;
      if (grant_fire) begin
        owner      <= grant;
        req_q.addr <= m_req_addr_i[grant];
        req_q.data <= m_req_data_i[grant];
        req_q.op   <= m_req_op_i[grant];
      end
      if (resp_fire) last_grant <= owner;
    end
  end

  assign dm_req_addr_o = req_q.addr;
  assign dm_req_data_o = req_q.data;
  assign dm_req_op_o   = req_q.op;
  assign busy_o        = (state != ST_IDLE);
  assign owner_o       = owner;
  assign state_o       = state;

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
// Directed bench for the two-master DMI arbiter: inputs change on the
// falling edge, outputs are sampled 1ns later.
module tb_riscv_dmi_arbiter;
  import riscv_dm_pkg::*;

  logic             clk;
  logic             rstn;
  logic [1:0]       m_req_valid;
  logic [1:0]       m_req_ready;
  logic [1:0][6:0]  m_req_addr;
  logic [1:0][31:0] m_req_data;
  logic [1:0][1:0]  m_req_op;
  logic [1:0]       m_resp_valid;
  logic [1:0]       m_resp_ready;
  logic [1:0][31:0] m_resp_data;
  logic [1:0][1:0]  m_resp_op;
  logic             dm_req_valid;
  logic             dm_req_ready;
  logic [6:0]       dm_req_addr;
  logic [31:0]      dm_req_data;
  logic [1:0]       dm_req_op;
  logic             dm_resp_valid;
  logic             dm_resp_ready;
  logic [31:0]      dm_resp_data;
  logic [1:0]       dm_resp_op;
  logic             busy;
  logic [0:0]       owner;
  arb_state_e       state;

  int total = 0;
  int bad   = 0;

  riscv_dmi_arbiter #(.NUM_MASTERS(2)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .m_req_valid_i   (m_req_valid),
    .m_req_ready_o   (m_req_ready),
    .m_req_addr_i    (m_req_addr),
    .m_req_data_i    (m_req_data),
    .m_req_op_i      (m_req_op),
    .m_resp_valid_o  (m_resp_valid),
    .m_resp_ready_i  (m_resp_ready),
    .m_resp_data_o   (m_resp_data),
    .m_resp_op_o     (m_resp_op),
    .dm_req_valid_o  (dm_req_valid),
    .dm_req_ready_i  (dm_req_ready),
    .dm_req_addr_o   (dm_req_addr),
    .dm_req_data_o   (dm_req_data),
    .dm_req_op_o     (dm_req_op),
    .dm_resp_valid_i (dm_resp_valid),
    .dm_resp_ready_o (dm_resp_ready),
    .dm_resp_data_i  (dm_resp_data),
    .dm_resp_op_i    (dm_resp_op),
    .busy_o          (busy),
    .owner_o         (owner),
    .state_o         (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn          = 1'b0;
    m_req_valid   = '0;
    m_req_addr    = '0;
    m_req_data    = '0;
    m_req_op      = '0;
    m_resp_ready  = '0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_resp_data  = '0;
    dm_resp_op    = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (m_req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", m_req_ready); end
    total++; if (dm_req_valid !== 1'b0) begin bad++; $display("FAIL reset_dm_req_valid got=%0b exp=0", dm_req_valid); end
    total++; if ({dm_req_addr, dm_req_data, dm_req_op} !== 41'd0) begin bad++; $display("FAIL reset_fields got=%h/%h/%h exp=0", dm_req_addr, dm_req_data, dm_req_op); end
    total++; if (m_resp_valid !== 2'b00 || dm_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b/%b exp=00/0", m_resp_valid, dm_resp_ready); end
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    m_req_valid = 2'b01; m_req_addr[0] = 7'h10; m_req_data[0] = 32'h8000_0001; m_req_op[0] = 2'd2;
    #1;
    total++; if (m_req_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", m_req_ready); end
    total++; if (dm_req_valid !== 1'b0) begin bad++; $display("FAIL single_dm_early got=%0b exp=0", dm_req_valid); end
    @(negedge clk);
    m_req_valid = 2'b00;
    #1;
    total++; if (dm_req_valid !== 1'b1) begin bad++; $display("FAIL single_dm_valid got=%0b exp=1", dm_req_valid); end
    total++; if (dm_req_addr !== 7'h10 || dm_req_data !== 32'h8000_0001 || dm_req_op !== 2'd2) begin
      bad++; $display("FAIL single_fields got=%h/%h/%h exp=10/80000001/2", dm_req_addr, dm_req_data, dm_req_op); end
    total++; if (busy !== 1'b1 || owner !== 1'b0 || m_req_ready !== 2'b00) begin
      bad++; $display("FAIL single_req_state got busy=%0b owner=%0d ready=%b exp 1/0/00", busy, owner, m_req_ready); end
    dm_req_ready = 1'b1;
    @(negedge clk);
    dm_req_ready = 1'b0; dm_resp_valid = 1'b1; dm_resp_data = 32'h0000_1234; dm_resp_op = 2'd0; m_resp_ready = 2'b11;
    #1;
    total++; if (m_resp_valid !== 2'b01) begin bad++; $display("FAIL single_resp_route got=%b exp=01", m_resp_valid); end
    total++; if (m_resp_data[0] !== 32'h0000_1234 || m_resp_op[0] !== 2'd0 || dm_resp_ready !== 1'b1) begin
      bad++; $display("FAIL single_resp_data got=%h/%0d/%0b exp=1234/0/1", m_resp_data[0], m_resp_op[0], dm_resp_ready); end
    total++; if (dm_req_valid !== 1'b0) begin bad++; $display("FAIL single_dm_valid_resp got=%0b exp=0", dm_req_valid); end
    @(negedge clk);
    dm_resp_valid = 1'b0; m_resp_ready = 2'b00;
    #1;
    total++; if (busy !== 1'b0 || m_resp_valid !== 2'b00) begin bad++; $display("FAIL single_done got busy=%0b rv=%b exp 0/00", busy, m_resp_valid); end
  endtask

  task automatic test_round_robin();
    logic       exp_g;
    logic [6:0] exp_addr;
    do_reset();
    @(negedge clk);
    m_req_valid = 2'b11; m_req_addr[0] = 7'h01; m_req_addr[1] = 7'h02;
    for (int t = 0; t < 4; t++) begin
      exp_g    = (t % 2 == 1);
      exp_addr = exp_g ? 7'h02 : 7'h01;
      #1;
      total++; if (m_req_ready !== (exp_g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant t=%0d got=%b exp_master=%0d", t, m_req_ready, exp_g); end
      @(negedge clk);
      #1;
      total++; if (owner !== exp_g || dm_req_addr !== exp_addr) begin
        bad++; $display("FAIL rr_owner t=%0d got owner=%0d addr=%h exp %0d/%h", t, owner, dm_req_addr, exp_g, exp_addr); end
      total++; if (m_req_ready !== 2'b00) begin bad++; $display("FAIL rr_no_ready_req t=%0d got=%b exp=00", t, m_req_ready); end
      dm_req_ready = 1'b1;
      @(negedge clk);
      dm_req_ready = 1'b0; dm_resp_valid = 1'b1; m_resp_ready = 2'b11;
      #1;
      total++; if (m_resp_valid !== (exp_g ? 2'b10 : 2'b01) || m_req_ready !== 2'b00) begin
        bad++; $display("FAIL rr_resp t=%0d got rv=%b ready=%b exp_master=%0d", t, m_resp_valid, m_req_ready, exp_g); end
      @(negedge clk);
      dm_resp_valid = 1'b0; m_resp_ready = 2'b00;
    end
    m_req_valid = 2'b00;
  endtask

  task automatic test_dm_stall();
    do_reset();
    @(negedge clk);
    m_req_valid = 2'b11; m_req_addr[0] = 7'h22; m_req_data[0] = 32'hA5A5_A5A5; m_req_op[0] = 2'd1;
    m_req_addr[1] = 7'h33; m_req_data[1] = 32'h1111_1111; m_req_op[1] = 2'd2;
    #1;
    total++; if (m_req_ready !== 2'b01) begin bad++; $display("FAIL stall_grant got=%b exp=01", m_req_ready); end
    @(negedge clk);
    m_req_valid = 2'b10;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (dm_req_valid !== 1'b1 || dm_req_addr !== 7'h22 || dm_req_data !== 32'hA5A5_A5A5 || dm_req_op !== 2'd1) begin
        bad++; $display("FAIL stall_hold k=%0d got v=%0b %h/%h/%0d exp 1 22/a5a5a5a5/1", k, dm_req_valid, dm_req_addr, dm_req_data, dm_req_op); end
      total++; if (m_req_ready !== 2'b00) begin bad++; $display("FAIL stall_no_ready k=%0d got=%b exp=00", k, m_req_ready); end
      if (k == 5) dm_req_ready = 1'b1;
      @(negedge clk);
    end
    dm_req_ready = 1'b0; m_req_valid = 2'b00; dm_resp_valid = 1'b1; m_resp_ready = 2'b01;
    #1;
    total++; if (m_resp_valid !== 2'b01 || state !== ST_RESP) begin bad++; $display("FAIL stall_resp got rv=%b state=%0d exp 01/%0d", m_resp_valid, state, ST_RESP); end
    @(negedge clk);
    dm_resp_valid = 1'b0; m_resp_ready = 2'b00;
  endtask

  task automatic test_resp_backpressure();
    int delivered = 0;
    do_reset();
    @(negedge clk);
    m_req_valid = 2'b10; m_req_addr[1] = 7'h05; m_req_data[1] = 32'h0; m_req_op[1] = 2'd1;
    #1;
    total++; if (m_req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", m_req_ready); end
    @(negedge clk);
    m_req_valid = 2'b00; dm_req_ready = 1'b1;
    @(negedge clk);
    dm_req_ready = 1'b0; dm_resp_valid = 1'b1; dm_resp_data = 32'hDEAD_BEEF; dm_resp_op = 2'd3; m_resp_ready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) m_resp_ready = 2'b10;
      #1;
      total++; if (m_resp_valid !== 2'b10) begin bad++; $display("FAIL bp_valid k=%0d got=%b exp=10", k, m_resp_valid); end
      total++; if (dm_resp_ready !== (k == 4)) begin bad++; $display("FAIL bp_dm_ready k=%0d got=%0b exp=%0b", k, dm_resp_ready, (k == 4)); end
      if (m_resp_valid[1] && m_resp_ready[1]) begin
        delivered++;
        total++; if (m_resp_data[1] !== 32'hDEAD_BEEF || m_resp_op[1] !== 2'd3) begin
          bad++; $display("FAIL bp_data got=%h/%0d exp=deadbeef/3", m_resp_data[1], m_resp_op[1]); end
      end
      @(negedge clk);
    end
    #1;
    if (m_resp_valid[1] && m_resp_ready[1]) delivered++;
    total++; if (m_resp_valid !== 2'b00 || dm_resp_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_after got rv=%b dr=%0b busy=%0b exp 00/0/0", m_resp_valid, dm_resp_ready, busy); end
    total++; if (delivered !== 1) begin bad++; $display("FAIL bp_once got=%0d exp=1", delivered); end
    @(negedge clk);
    dm_resp_valid = 1'b0; m_resp_ready = 2'b00;
  endtask

  task automatic test_spurious_resp();
    do_reset();
    @(negedge clk);
    dm_resp_valid = 1'b1; dm_resp_data = 32'h5555_AAAA; m_resp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (m_resp_valid !== 2'b00 || dm_resp_ready !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL spurious k=%0d got rv=%b dr=%0b busy=%0b exp 00/0/0", k, m_resp_valid, dm_resp_ready, busy); end
      @(negedge clk);
    end
    dm_resp_valid = 1'b0; m_resp_ready = 2'b00;
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    @(negedge clk);
    m_req_valid = 2'b10; m_req_addr[1] = 7'h05; m_req_data[1] = 32'h0BAD_F00D; m_req_op[1] = 2'd2;
    @(negedge clk);
    m_req_valid = 2'b00; dm_req_ready = 1'b1;
    @(negedge clk);
    dm_req_ready = 1'b0; dm_resp_valid = 1'b1; m_resp_ready = 2'b00;
    #1;
    total++; if (state !== ST_RESP || owner !== 1'b1) begin bad++; $display("FAIL rir_pre got state=%0d owner=%0d exp %0d/1", state, owner, ST_RESP); end
    #1 rstn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || state !== ST_IDLE || owner !== 1'b0) begin
      bad++; $display("FAIL rir_async got busy=%0b state=%0d owner=%0d exp 0/%0d/0", busy, state, owner, ST_IDLE); end
    total++; if (m_resp_valid !== 2'b00 || dm_resp_ready !== 1'b0 || dm_req_valid !== 1'b0 || dm_req_addr !== 7'h00) begin
      bad++; $display("FAIL rir_outputs got rv=%b dr=%0b dv=%0b addr=%h exp 00/0/0/00", m_resp_valid, dm_resp_ready, dm_req_valid, dm_req_addr); end
    @(negedge clk);
    rstn = 1'b1; dm_resp_valid = 1'b0; m_req_valid = 2'b11;
    #1;
    total++; if (m_req_ready !== 2'b01) begin bad++; $display("FAIL rir_regrant got=%b exp=01", m_req_ready); end
    @(negedge clk);
    m_req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_dm_stall();
    test_resp_backpressure();
    test_spurious_resp();
    test_reset_in_resp();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
